// File: rtl/ysyx_22050854_cpu_pkg.sv
// Shared definitions for the NPC integer datapath.
//
// Contents:
//   XLEN_DEF / NREG_DEF : default register width and architectural register count
//   REG_ZERO            : index of the hardwired-zero register
//   addr_width()        : register address width for a given register count
//
// Configuration macro consumed by the register file:
//   YSYX_22050854_RF_BYPASS_EN (same-cycle write-to-read forwarding)
package ysyx_22050854_cpu_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

    // At least one address bit, even for the degenerate two-register file.
    function automatic int addr_width(input int nreg);
        return (nreg <= 2) ? 1 : $clog2(nreg);
    endfunction

endpackage

// File: rtl/ysyx_22050854_rf_scoreboard.sv
// Busy-bit scoreboard: one "result pending" bit per architectural register.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   iss_valid, iss_rd  : an instruction with destination iss_rd issued this cycle
//   flush              : clear every busy bit
//   wen0/waddr0        : EXU writeback (clears the bit of its destination)
//   wen1/waddr1        : LSU writeback (clears the bit of its destination)
//   raddr              : packed read addresses, port i at [i*AW +: AW]
//   busy_lookup        : per-port busy bit of the addressed register (registered bits)
//   any_busy           : OR of all busy bits
//
// iss_valid is a one-sided valid: there is no ready, the bit is set on every
// posedge where iss_valid is high. Stalling is the IDU's job, driven by busy_lookup.
//
// Same-edge priority: rst > issue set > flush / writeback clear.
module ysyx_22050854_rf_scoreboard
    import ysyx_22050854_cpu_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int AW   = addr_width(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    input  logic              wen0,
    input  logic [AW-1:0]     waddr0,
    input  logic              wen1,
    input  logic [AW-1:0]     waddr1,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    busy_lookup,
    output logic              any_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy_q;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wen0) busy_nxt[waddr0] = 1'b0;
            if (wen1) busy_nxt[waddr1] = 1'b0;
        end
        // Applied last: a younger producer issued this cycle stays outstanding
        // even when an older writeback or a flush hits the same register.
        if (iss_valid) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_nxt;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_lookup
        assign busy_lookup[i] = busy_q[raddr[i*AW +: AW]];
    end

    assign any_busy = |busy_q;

endmodule

// File: rtl/ysyx_22050854_regfile_sb.sv
// Integer register file with integrated busy-bit scoreboard.
//
// Parameters: XLEN (register width), NREG (register count, power of two),
//             NRD (read ports); AW is derived from NREG.
// Ports:
//   clk, rst              : clock, synchronous active-high reset (clears regs and busy bits)
//   wen0/waddr0/wdata0    : EXU writeback port
//   wen1/waddr1/wdata1    : LSU writeback port, wins over port 0 on the same address
//   raddr / rdata         : packed combinational read ports
//   rbusy                 : per-read-port operand-pending flag
//   iss_valid / iss_rd    : destination of an issued instruction (marks it busy)
//   flush                 : clear all busy bits
//   any_busy              : OR of all busy bits
//
// Macro YSYX_22050854_RF_BYPASS_EN: forward same-cycle writes onto rdata and
// drop rbusy for that port; undefined, reads see registered state only.
module ysyx_22050854_regfile_sb
    import ysyx_22050854_cpu_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    localparam int AW   = addr_width(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wen0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                wen1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic                any_busy
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [XLEN-1:0] rf [NREG];
    logic [NRD-1:0]  sb_busy;
    logic            sb_any;

    // Port 1 is written second so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (wen0 && waddr0 != ZERO_ADDR) rf[waddr0] <= wdata0;
            if (wen1 && waddr1 != ZERO_ADDR) rf[waddr1] <= wdata1;
        end
    end

    ysyx_22050854_rf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .flush       (flush),
        .wen0        (wen0),
        .waddr0      (waddr0),
        .wen1        (wen1),
        .waddr1      (waddr1),
        .raddr       (raddr),
        .busy_lookup (sb_busy),
        .any_busy    (sb_any)
    );

    // Outputs read as cleared while rst is held, not only after the edge.
    assign any_busy = sb_any & ~rst;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            ra_nz;
        logic            hit0;
        logic            hit1;
        logic [XLEN-1:0] rd_val;

        assign ra    = raddr[i*AW +: AW];
        assign ra_nz = (ra != ZERO_ADDR);

`ifdef YSYX_22050854_RF_BYPASS_EN
        assign hit1 = wen1 && (waddr1 == ra) && ra_nz;
        assign hit0 = wen0 && (waddr0 == ra) && ra_nz;
`else
        assign hit1 = 1'b0;
        assign hit0 = 1'b0;
`endif

        // Forwarding applies even under rst: the write is seen, just not stored.
        always_comb begin
            rd_val = '0;
            if (hit1)                rd_val = wdata1;
            else if (hit0)           rd_val = wdata0;
            else if (ra_nz && !rst)  rd_val = rf[ra];
        end

        assign rdata[i*XLEN +: XLEN] = rd_val;
        assign rbusy[i] = sb_busy[i] & ~hit0 & ~hit1 & ~rst;
    end

endmodule

// File: tb/tb_ysyx_22050854_regfile_sb.sv
module tb_ysyx_22050854_regfile_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                wen0, wen1;
    logic [AW-1:0]       waddr0, waddr1;
    logic [XLEN-1:0]     wdata0, wdata1;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic                any_busy;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22050854_regfile_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wen0      (wen0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .wen1      (wen1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .any_busy  (any_busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Inputs change 1 ns after posedge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen0 = 0; waddr0 = '0; wdata0 = '0;
        wen1 = 0; waddr1 = '0; wdata1 = '0;
        iss_valid = 0; iss_rd = '0; flush = 0;
    endtask

    task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    function automatic logic [XLEN-1:0] rd(input int p);
        return rdata[p*XLEN +: XLEN];
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        wen0 = 1; waddr0 = 5; wdata0 = 64'hDEAD;
        iss_valid = 1; iss_rd = 5;
        tick();
        idle();
        set_raddr(5, 5);
        n_tests++;
        if (rd(0) !== 64'hDEAD || any_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre: x5=%h any_busy=%b, want 000000000000dead 1", rd(0), any_busy);
        end
        rst = 1;
        tick();
        rst = 0;
        #1;
        n_tests++;
        if (rd(0) !== 64'h0 || rd(1) !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: x5=%h/%h, want 0", rd(0), rd(1));
        end
        n_tests++;
        if (any_busy !== 1'b0 || rbusy !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_busy: any_busy=%b rbusy=%b, want 0 00", any_busy, rbusy);
        end
    endtask

    task automatic test_x0();
        idle();
        wen0 = 1; waddr0 = 0; wdata0 = 64'hFFFF;
        wen1 = 1; waddr1 = 0; wdata1 = 64'h1234;
        iss_valid = 1; iss_rd = 0;
        tick();
        idle();
        set_raddr(0, 0);
        n_tests++;
        if (rd(0) !== 64'h0 || rd(1) !== 64'h0 || rbusy !== 2'b00 || any_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL x0: rdata=%h/%h rbusy=%b any=%b, want 0/0 00 0",
                     rd(0), rd(1), rbusy, any_busy);
        end
    endtask

    task automatic test_collision();
        idle();
        wen0 = 1; waddr0 = 7; wdata0 = 64'h1111;
        wen1 = 1; waddr1 = 7; wdata1 = 64'h2222;
        tick();
        idle();
        set_raddr(0, 7);
        n_tests++;
        if (rd(1) !== 64'h2222) begin
            n_fail++;
            $display("FAIL collision: x7=%h, want 0000000000002222", rd(1));
        end
        // Both ports to different registers in one cycle.
        wen0 = 1; waddr0 = 1; wdata0 = 64'hA5A5_0001;
        wen1 = 1; waddr1 = 2; wdata1 = 64'h5A5A_0002;
        tick();
        idle();
        set_raddr(1, 2);
        n_tests++;
        if (rd(0) !== 64'hA5A5_0001 || rd(1) !== 64'h5A5A_0002) begin
            n_fail++;
            $display("FAIL dual_write: x1=%h x2=%h, want a5a50001 5a5a0002", rd(0), rd(1));
        end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_valid = 1; iss_rd = 10;
        tick();
        idle();
        set_raddr(10, 11);
        n_tests++;
        if (rbusy !== 2'b01 || any_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set: rbusy=%b any=%b, want 01 1", rbusy, any_busy);
        end
        wen1 = 1; waddr1 = 10; wdata1 = 64'h55;
        #1;
        n_tests++;
`ifdef YSYX_22050854_RF_BYPASS_EN
        if (rbusy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_clear_same: rbusy0=%b, want 0", rbusy[0]);
        end
`else
        if (rbusy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_clear_same: rbusy0=%b, want 1", rbusy[0]);
        end
`endif
        tick();
        idle();
        #1;
        n_tests++;
        if (rbusy !== 2'b00 || any_busy !== 1'b0 || rd(0) !== 64'h55) begin
            n_fail++;
            $display("FAIL sb_clear: rbusy=%b any=%b x10=%h, want 00 0 55", rbusy, any_busy, rd(0));
        end
        // Set and clear of x10 in one cycle: stays busy.
        iss_valid = 1; iss_rd = 10;
        wen0 = 1; waddr0 = 10; wdata0 = 64'h66;
        tick();
        idle();
        #1;
        n_tests++;
        if (rbusy[0] !== 1'b1 || rd(0) !== 64'h66) begin
            n_fail++;
            $display("FAIL sb_set_wins: rbusy0=%b x10=%h, want 1 66", rbusy[0], rd(0));
        end
        wen0 = 1; waddr0 = 10; wdata0 = 64'h77;
        tick();
        idle();
        #1;
        n_tests++;
        if (rbusy[0] !== 1'b0 || any_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_clear2: rbusy0=%b any=%b, want 0 0", rbusy[0], any_busy);
        end
    endtask

    task automatic test_flush();
        idle();
        iss_valid = 1; iss_rd = 3; tick();
        iss_rd = 4; tick();
        iss_rd = 9; tick();
        idle();
        set_raddr(3, 9);
        n_tests++;
        if (rbusy !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_pre: rbusy=%b, want 11", rbusy);
        end
        flush = 1; iss_valid = 1; iss_rd = 12;
        tick();
        idle();
        set_raddr(3, 4);
        n_tests++;
        if (rbusy !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_cleared: rbusy(x3,x4)=%b, want 00", rbusy);
        end
        set_raddr(9, 12);
        n_tests++;
        if (rbusy !== 2'b10 || any_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_issue: rbusy(x9,x12)=%b any=%b, want 10 1", rbusy, any_busy);
        end
        flush = 1;
        tick();
        idle();
        #1;
        n_tests++;
        if (any_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_all: any=%b, want 0", any_busy);
        end
    endtask

    task automatic test_bypass();
        idle();
        // x8 = 1234 and busy (set wins over the same-cycle write).
        wen0 = 1; waddr0 = 8; wdata0 = 64'h1234;
        iss_valid = 1; iss_rd = 8;
        tick();
        idle();
        set_raddr(8, 8);
        wen0 = 1; waddr0 = 8; wdata0 = 64'hABCD;
        #1;
        n_tests++;
`ifdef YSYX_22050854_RF_BYPASS_EN
        if (rd(0) !== 64'hABCD || rbusy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_same: rdata=%h rbusy=%b, want abcd 0", rd(0), rbusy[0]);
        end
`else
        if (rd(0) !== 64'h1234 || rbusy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_same: rdata=%h rbusy=%b, want 1234 1", rd(0), rbusy[0]);
        end
`endif
        tick();
        idle();
        #1;
        n_tests++;
        if (rd(0) !== 64'hABCD || rbusy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_next: rdata=%h rbusy=%b, want abcd 0", rd(0), rbusy[0]);
        end
        // Both ports writing the read address: port 1 forwarded.
        wen0 = 1; waddr0 = 8; wdata0 = 64'hC0;
        wen1 = 1; waddr1 = 8; wdata1 = 64'hC1;
        #1;
        n_tests++;
`ifdef YSYX_22050854_RF_BYPASS_EN
        if (rd(1) !== 64'hC1) begin
            n_fail++;
            $display("FAIL bypass_prio: rdata=%h, want c1", rd(1));
        end
`else
        if (rd(1) !== 64'hABCD) begin
            n_fail++;
            $display("FAIL bypass_prio: rdata=%h, want abcd", rd(1));
        end
`endif
        tick();
        idle();
        #1;
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] v;
        idle();
        for (int i = 1; i < 16; i++) begin
            wen0 = 1; waddr0 = AW'(i); wdata0 = 64'h0101_0000_0000_0000 + 64'(i * 17);
            if (i > 1) set_raddr(0, AW'(i - 1));
            else       set_raddr(0, 0);
            if (i > 1) begin
                v = 64'h0101_0000_0000_0000 + 64'((i - 1) * 17);
                n_tests++;
                if (rd(1) !== v) begin
                    n_fail++;
                    $display("FAIL b2b_prev x%0d: got %h, want %h", i - 1, rd(1), v);
                end
            end
            tick();
        end
        idle();
        for (int i = 1; i < 16; i += 2) begin
            set_raddr(AW'(i), AW'(i + 1));
            v = 64'h0101_0000_0000_0000 + 64'(i * 17);
            n_tests++;
            if (rd(0) !== v) begin
                n_fail++;
                $display("FAIL b2b_read x%0d: got %h, want %h", i, rd(0), v);
            end
        end
    endtask

    // ---------------- main ----------------
    initial begin
        idle();
        raddr = '0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        test_reset();
        test_x0();
        test_collision();
        test_scoreboard();
        test_flush();
        test_bypass();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050854_regfile_sb.md
Name: ysyx_22050854_regfile_sb

Overview:
Parametrised integer register file for the next NPC core generation.
- Configurable width, register count and read-port count.
- Two write ports: EXU writeback (port 0) and LSU writeback (port 1).
- x0 hardwired to zero; all registers are real storage with synchronous reset.
- Integrated busy-bit scoreboard so the IDU stalls on pending producers; optional write-to-read bypass.

Parameters:
XLEN, 64, data width of each register
NREG, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports
AW, $clog2(NREG), address width (localparam, derived, not overridable)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
wen0  input  1  write enable, port 0 (EXU)
waddr0  input  AW  write address, port 0
wdata0  input  XLEN  write data, port 0
wen1  input  1  write enable, port 1 (LSU)
waddr1  input  AW  write address, port 1
wdata1  input  XLEN  write data, port 1
raddr  input  NRD*AW  packed read addresses; port i at [i*AW +: AW]
rdata  output  NRD*XLEN  packed read data; port i at [i*XLEN +: XLEN]
rbusy  output  NRD  per-read-port "operand pending" flag
iss_valid  input  1  instruction issued with a destination register
iss_rd  input  AW  destination of issued instruction
flush  input  1  clear all busy bits (pipeline flush)
any_busy  output  1  OR of all busy bits

Behaviour:
- Reset (rst=1 at posedge): all registers cleared to 0, all busy bits cleared. Reset has priority over every other input.
- Outputs during and after reset:
  - rdata all zero; rbusy=0; any_busy=0.
  - Under RF_BYPASS_EN, a write presented in the same cycle as rst is still forwarded combinationally on rdata, but is not stored.
- Writes take effect at posedge.
  - Writes to address 0 are ignored; reg 0 always reads 0.
  - wen0 and wen1 to the same nonzero address in one cycle: port 1 (LSU) wins.
- Reads are combinational from storage: rdata_i = rf[raddr_i].
  - Read latency 0; a write is visible to reads the cycle after the edge (no bypass).
- Scoreboard: one busy bit per register, bit 0 constant 0.
  - Set at posedge when iss_valid and iss_rd!=0.
  - Cleared at posedge by any write (wen0/wen1) to that address.
  - Same register set and cleared in one cycle: set wins (younger producer outstanding).
  - flush clears all busy bits; flush and iss_valid in the same cycle: the issue still sets its bit (issue is post-flush).
  - rst overrides all.
- rbusy_i = busy[raddr_i] (registered bits; combinational lookup). raddr_i=0 always gives rbusy_i=0.
- any_busy = |busy, combinational from registered bits.
- Out-of-range addresses cannot occur: NREG is a power of two.

Optional Feature:
Macro: YSYX_22050854_RF_BYPASS_EN
- Defined: same-cycle write-to-read forwarding.
  - rdata_i = wdata1 if wen1 && waddr1==raddr_i && raddr_i!=0.
  - Else wdata0 on the same condition for port 0.
  - Else storage.
  - rbusy_i is forced 0 when a matching write is present in that cycle.
- Undefined: no forwarding. rdata/rbusy reflect registered state only; the IDU stalls one extra cycle on the dependency.

Decomposition:
Shared package ysyx_22050854_cpu_pkg holds:
- XLEN default, NREG default;
- REG_ZERO=0 constant;
- localparam-style address width helper.

Natural sub-module: ysyx_22050854_rf_scoreboard, holding the busy vector, set/clear/flush priority logic, any_busy, and per-port busy lookup. The parent holds storage, write arbitration and bypass muxing.

Test Plan:
- Reset: write 64'hDEAD to x5, then rst=1 for one cycle -> x5 reads 0, any_busy=0, rbusy=0 on all ports.
- x0 protection: wen0=1, waddr0=0, wdata0=64'hFFFF -> next cycle raddr=0 gives rdata=0, rbusy=0.
- Write collision: wen0 to x7=64'h1111 and wen1 to x7=64'h2222 in the same cycle -> x7 reads 64'h2222.
- Scoreboard: iss_valid, iss_rd=10 -> rbusy=1 for raddr=10 next cycle. wen1 waddr1=10 the next cycle -> busy clears after that edge. Set and clear of x10 in the same cycle -> remains busy.
- Flush: set busy on x3, x4, x9; assert flush with iss_valid iss_rd=12 -> after edge only x12 busy, any_busy=1.
- Bypass:
  - With macro defined: raddr=8, wen0 waddr0=8 wdata0=64'hABCD in the same cycle -> rdata=64'hABCD, rbusy=0.
  - Without macro: old value that cycle, 64'hABCD the next cycle.
